// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and default opcodes for the instruction fetch unit.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DRAIN    = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OPC_J   = 6'h02;
  localparam logic [5:0] OPC_BEQ = 6'h04;
  localparam logic [5:0] OPC_BNE = 6'h05;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Circular instruction buffer; pointers wrap naturally since DEPTH is a power of two.
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  import instr_fetch_unit_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]             wptr_q, rptr_q;
  logic [CW-1:0]             cnt_q;
  logic [DEPTH-1:0][W-1:0]   mem_q;
  logic                      do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0) && !flush_i;
  assign do_push = push_i && !flush_i && ((cnt_q != FULL) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; the head is masked by the consumer while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetcher: pc handshake -> memory read -> buffer -> head decode.
module instr_fetch_unit #(
  parameter int         DEPTH   = 2,
  parameter logic [5:0] OPC_J   = instr_fetch_unit_pkg::OPC_J,
  parameter logic [5:0] OPC_BEQ = instr_fetch_unit_pkg::OPC_BEQ,
  parameter logic [5:0] OPC_BNE = instr_fetch_unit_pkg::OPC_BNE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_addr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [25:0] imm26,
  output logic [15:0] imm16,
  output logic        j,
  output logic        beq,
  output logic        bne,
  output logic        misalign_err
);
  import instr_fetch_unit_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          mis_q, mis_d;
  logic [CW-1:0] count;
  fetch_entry_t  wentry, hentry;
  logic          inflight, hs, aligned, push, pop;

  // Only a WAIT_ACK fetch will land in the buffer; a DRAIN fetch is discarded.
  assign inflight = (state_q == WAIT_ACK);
  assign pc_ready = (state_q == IDLE) && !flush &&
                    (({1'b0, count} + {{CW{1'b0}}, inflight}) < {1'b0, DEPTH_C});
  assign hs       = pc_valid && pc_ready;
  assign aligned  = (pc_addr[1:0] == 2'b00);
  assign push     = inflight && mem_ack && !flush;
  assign pop      = instr_valid && instr_ready;
  assign wentry   = '{data: mem_rdata, addr: addr_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mis_d   = hs && !aligned;
    case (state_q)
      IDLE: begin
        if (hs && aligned) begin
          addr_d  = pc_addr;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (mem_ack)    state_d = IDLE;
        else if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state_q == WAIT_ACK) || (state_q == DRAIN);
  end

  assign mem_addr     = addr_q[31:2];
  assign misalign_err = mis_q;

  instr_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (hentry),
    .count_o (count)
  );

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? hentry.data : '0;
  assign instr_addr  = instr_valid ? hentry.addr : '0;
  assign imm26       = instr[25:0];
  assign imm16       = instr[15:0];
  assign j           = instr_valid && (instr[31:26] == OPC_J);
  assign beq         = instr_valid && (instr[31:26] == OPC_BEQ);
  assign bne         = instr_valid && (instr[31:26] == OPC_BNE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: scripted vector table, corner-case sequences, random run vs. queue model.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_valid, pc_ready, flush;
  logic        mem_req, mem_ack;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata, instr, instr_addr;
  logic        instr_valid, instr_ready;
  logic [25:0] imm26;
  logic [15:0] imm16;
  logic        j, beq, bne, misalign_err;

  int n_chk = 0;
  int n_pass = 0;

  instr_fetch_unit #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr(instr), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .imm26(imm26), .imm16(imm16),
    .j(j), .beq(beq), .bne(bne), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    pc_valid = 0; pc_addr = '0; flush = 0; mem_ack = 0; mem_rdata = '0; instr_ready = 0;
  endtask

  typedef struct {
    logic        pv;
    logic [31:0] pa;
    logic        fl;
    logic        ack;
    logic [31:0] rd;
    logic        rdy;
    logic        e_prdy;
    logic        e_req;
    logic [29:0] e_maddr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_iaddr;
    logic [2:0]  e_dec;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [31:0] a;
  } ent_t;

  vec_t vt[9];
  ent_t q[$];

  initial begin
    // pv pa fl ack rd rdy | prdy req maddr iv instr iaddr dec mis
    vt[0] = '{1, 32'h10, 0, 0, 32'h0,         0, 1, 1, 30'h4, 0, 32'h0,         32'h0,  3'b000, 0};
    vt[1] = '{0, 32'h0,  0, 1, 32'h0800_0040, 0, 0, 0, 30'h4, 1, 32'h0800_0040, 32'h10, 3'b100, 0};
    vt[2] = '{0, 32'h0,  0, 0, 32'h0,         1, 1, 0, 30'h4, 0, 32'h0,         32'h0,  3'b000, 0};
    vt[3] = '{1, 32'h6,  0, 0, 32'h0,         0, 1, 0, 30'h4, 0, 32'h0,         32'h0,  3'b000, 1};
    vt[4] = '{0, 32'h0,  0, 0, 32'h0,         0, 1, 0, 30'h4, 0, 32'h0,         32'h0,  3'b000, 0};
    vt[5] = '{1, 32'h20, 1, 0, 32'h0,         0, 0, 0, 30'h4, 0, 32'h0,         32'h0,  3'b000, 0};
    vt[6] = '{1, 32'h14, 0, 0, 32'h0,         0, 1, 1, 30'h5, 0, 32'h0,         32'h0,  3'b000, 0};
    vt[7] = '{0, 32'h0,  0, 1, 32'h1000_1234, 0, 0, 0, 30'h5, 1, 32'h1000_1234, 32'h14, 3'b010, 0};
    vt[8] = '{0, 32'h0,  0, 0, 32'h0,         1, 1, 0, 30'h5, 0, 32'h0,         32'h0,  3'b000, 0};

    idle_in();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst instr_valid", instr_valid, 0);
    chk("rst misalign", misalign_err, 0);
    chk("rst decode", {j, beq, bne}, 0);
    chk("rst instr", instr, 0);
    chk("rst instr_addr", instr_addr, 0);
    rst = 0;

    // Scripted vectors: basic fetch, misaligned drop, flush blocking acceptance
    for (int i = 0; i < 9; i++) begin
      pc_valid = vt[i].pv; pc_addr = vt[i].pa; flush = vt[i].fl;
      mem_ack = vt[i].ack; mem_rdata = vt[i].rd; instr_ready = vt[i].rdy;
      #1;
      chk($sformatf("vec%0d pc_ready", i), pc_ready, vt[i].e_prdy);
      tick();
      idle_in();
      chk($sformatf("vec%0d mem_req", i), mem_req, vt[i].e_req);
      chk($sformatf("vec%0d mem_addr", i), mem_addr, vt[i].e_maddr);
      chk($sformatf("vec%0d instr_valid", i), instr_valid, vt[i].e_iv);
      chk($sformatf("vec%0d decode", i), {j, beq, bne}, vt[i].e_dec);
      chk($sformatf("vec%0d misalign", i), misalign_err, vt[i].e_mis);
      if (vt[i].e_iv) begin
        chk($sformatf("vec%0d instr", i), instr, vt[i].e_instr);
        chk($sformatf("vec%0d instr_addr", i), instr_addr, vt[i].e_iaddr);
        chk($sformatf("vec%0d imm26", i), imm26, vt[i].e_instr[25:0]);
        chk($sformatf("vec%0d imm16", i), imm16, vt[i].e_instr[15:0]);
      end
    end

    // Stalled consumer: two fetches fill the buffer, third waits for a pop
    pc_valid = 1; pc_addr = 32'h0; #1;
    chk("stall prdy0", pc_ready, 1);
    tick(); pc_valid = 0; mem_ack = 1; mem_rdata = 32'hAAAA_0000;
    tick(); mem_ack = 0; pc_valid = 1; pc_addr = 32'h4; #1;
    chk("stall prdy1", pc_ready, 1);
    tick(); pc_valid = 0; mem_ack = 1; mem_rdata = 32'hBBBB_0004;
    tick(); mem_ack = 0; pc_valid = 1; pc_addr = 32'h8;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall full prdy", pc_ready, 0);
      chk("stall full req", mem_req, 0);
      tick();
    end
    chk("stall head", instr_addr, 32'h0);
    instr_ready = 1; #1;
    chk("stall pop prdy", pc_ready, 0);
    tick(); instr_ready = 0; #1;
    chk("stall after pop prdy", pc_ready, 1);
    chk("stall after pop head", instr_addr, 32'h4);
    tick(); pc_valid = 0;
    chk("stall third req", mem_req, 1);
    chk("stall third addr", mem_addr, 30'h2);
    flush = 1;
    tick(); flush = 0;
    chk("stall flush iv", instr_valid, 0);
    chk("stall flush drain req", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h0;
    tick(); idle_in();
    chk("stall drained req", mem_req, 0);

    // Flush during WAIT_ACK, ack three cycles later
    pc_valid = 1; pc_addr = 32'h40;
    tick(); pc_valid = 0; flush = 1;
    tick(); flush = 0; #1;
    chk("drain req", mem_req, 1);
    chk("drain addr", mem_addr, 30'h10);
    chk("drain prdy", pc_ready, 0);
    tick(); tick();
    chk("drain req held", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h1000_0001;
    tick(); mem_ack = 0; #1;
    chk("drain done req", mem_req, 0);
    chk("drain done iv", instr_valid, 0);
    chk("drain done prdy", pc_ready, 1);
    tick();
    chk("drain iv later", instr_valid, 0);

    // Push+pop same cycle with one entry, then flush with mem_ack
    pc_valid = 1; pc_addr = 32'h100;
    tick(); pc_valid = 0; mem_ack = 1; mem_rdata = 32'h0000_00A1;
    tick(); mem_ack = 0; pc_valid = 1; pc_addr = 32'h104;
    tick(); pc_valid = 0; mem_ack = 1; mem_rdata = 32'h1400_00B2; instr_ready = 1;
    tick(); mem_ack = 0; instr_ready = 0; #1;
    chk("pp iv", instr_valid, 1);
    chk("pp head", instr_addr, 32'h104);
    chk("pp bne", bne, 1);
    chk("pp count1 prdy", pc_ready, 1);
    pc_valid = 1; pc_addr = 32'h108;
    tick(); pc_valid = 0; flush = 1; mem_ack = 1; mem_rdata = 32'h0800_0000;
    tick(); flush = 0; mem_ack = 0; #1;
    chk("fa iv", instr_valid, 0);
    chk("fa req", mem_req, 0);
    chk("fa prdy", pc_ready, 1);

    // Reset in WAIT_ACK; stray ack afterwards must not create an entry
    pc_valid = 1; pc_addr = 32'h200;
    tick(); pc_valid = 0;
    chk("rw req", mem_req, 1);
    #2 rst = 1; #1;
    chk("rw req immediate", mem_req, 0);
    chk("rw addr", mem_addr, 0);
    tick(); rst = 0;
    tick(); mem_ack = 1; mem_rdata = 32'h0800_0001;
    tick(); mem_ack = 0;
    chk("rw stray iv", instr_valid, 0);
    chk("rw stray req", mem_req, 0);

    // Random run against a queue-level model
    begin
      logic        pend, drop, mis_exp, hs, e_prdy, e_iv;
      logic [31:0] paddr, last_addr, hd;
      logic [31:0] addr, rd;
      logic [5:0]  opc;
      pend = 0; drop = 0; mis_exp = 0; paddr = 0; last_addr = 0;
      q.delete();
      for (int c = 0; c < 400; c++) begin
        addr = $urandom & 32'h0000_FFFC;
        if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
        case ($urandom_range(0, 3))
          0: opc = 6'h02;
          1: opc = 6'h04;
          2: opc = 6'h05;
          default: opc = 6'($urandom);
        endcase
        rd = {opc, 26'($urandom)};
        pc_valid = 1'($urandom_range(0, 1));
        pc_addr = addr;
        flush = ($urandom_range(0, 9) == 0);
        mem_ack = ($urandom_range(0, 2) == 0);
        mem_rdata = rd;
        instr_ready = 1'($urandom_range(0, 1));
        #1;
        e_prdy = !pend && (q.size() < 2) && !flush;
        e_iv = (q.size() > 0);
        hd = e_iv ? q[0].d : 32'h0;
        chk("rnd pc_ready", pc_ready, e_prdy);
        chk("rnd mem_req", mem_req, pend);
        chk("rnd mem_addr", mem_addr, last_addr[31:2]);
        chk("rnd instr_valid", instr_valid, e_iv);
        chk("rnd misalign", misalign_err, mis_exp);
        chk("rnd decode", {j, beq, bne},
            {e_iv && hd[31:26] == 6'h02, e_iv && hd[31:26] == 6'h04, e_iv && hd[31:26] == 6'h05});
        if (e_iv) begin
          chk("rnd instr", instr, q[0].d);
          chk("rnd instr_addr", instr_addr, q[0].a);
        end
        hs = pc_valid && e_prdy;
        if (flush) begin
          q.delete();
          if (pend && mem_ack) pend = 0;
          else if (pend) drop = 1;
        end else begin
          if (q.size() > 0 && instr_ready) void'(q.pop_front());
          if (pend && mem_ack) begin
            if (!drop) q.push_back('{d: rd, a: paddr});
            pend = 0;
          end
        end
        mis_exp = hs && (addr[1:0] != 2'b00);
        if (hs && addr[1:0] == 2'b00) begin
          pend = 1; drop = 0; paddr = addr; last_addr = addr;
        end
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
